dual_issue_sequencer: RTL and testbench
=======================================

# dual_issue_sequencer

Issue-stage sequencer that sits between fetch and the two execute lanes of the dual-issue core. It accepts instruction pairs from fetch and issues both together when they are independent. When the dependence detector flags a read-after-write hazard from i0 to i1, it issues them one at a time. It consumes the `has_RAW_dependence` output of the dependence detector, computed combinationally from the same `in_i0`/`in_i1` it presents, and keeps a split counter for performance analysis.

## Interface
Parameters:
- `CNT_W`, default 16: width of the split counter.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  fetch presents a pair.
- `in_ready`  output  1  sequencer accepts the pair this cycle.
- `in_i0`  input  32  older instruction.
- `in_i1`  input  32  younger instruction.
- `in_i1_valid`  input  1  `in_i1` is meaningful; 0 means a single-instruction group.
- `has_RAW_dependence`  input  1  from the dependence detector; i1 reads a register that i0 writes.
- `flush`  input  1  discard all held and issued-but-unaccepted instructions.
- `out_ready`  input  1  execute lanes accept the current output.
- `out_valid0`  output  1  lane 0 holds a valid instruction.
- `out_instr0`  output  32  lane 0 instruction.
- `out_valid1`  output  1  lane 1 holds a valid instruction.
- `out_instr1`  output  32  lane 1 instruction.
- `split_count`  output  `CNT_W`  number of pairs split because of RAW; wraps modulo 2^`CNT_W`.

## Operation
- Two states:
  - RUN: normal operation.
  - SPLIT: i1 of a split pair sits in the internal hold register.
- `adv = !out_valid0 || out_ready`: the output register may load this cycle.
- `in_ready = (state == RUN) && adv && !flush`.
- Accept means `in_valid && in_ready`.

In RUN:
- Accept with `in_i1_valid && has_RAW_dependence`:
  - lane 0 = `in_i0`, valid; lane 1 invalid.
  - hold = `in_i1`; state goes to SPLIT.
  - `split_count` += 1.
- Accept otherwise:
  - lane 0 = `in_i0`, valid.
  - lane 1 = `in_i1`, valid iff `in_i1_valid`.
  - `has_RAW_dependence` is ignored when `in_i1_valid` = 0.
- `adv` with no accept: `out_valid0` and `out_valid1` clear to 0; instruction data is don't-care.
- No `adv`: outputs hold.

In SPLIT:
- `adv`: lane 0 = hold, valid; lane 1 invalid; state goes to RUN.
- No `adv`: outputs and hold are unchanged.
- `in_ready` = 0, so no new pair is taken in the same cycle the held i1 issues.

Ordering and invariants:
- Lane 0 is always older than lane 1.
- `out_valid1` = 1 implies `out_valid0` = 1.

Flush (synchronous, priority below `rst`, above everything else):
- Next cycle: `out_valid0` = `out_valid1` = 0, state = RUN, hold discarded.
- `split_count` is unchanged, including for a pair accepted in the flush cycle. None is accepted, because `in_ready` = 0 during flush.

Reset:
- State = RUN.
- `out_valid0` = `out_valid1` = 0.
- `out_instr0` = `out_instr1` = 32'h0.
- hold = 0.
- `split_count` = 0.
- Reset in SPLIT discards the held i1.

## Timing
- Output is registered: a pair accepted in cycle N appears on the lanes in N+1.
- The second half of a split pair appears in N+2 at the earliest, or later under back-pressure.
- Throughput:
  - Independent pairs: one pair per cycle.
  - Split pairs: two cycles per pair with `out_ready` held high.
- `in_ready` is combinational from `out_ready`, `out_valid0`, `flush` and state.
- `has_RAW_dependence` is sampled only in the accept cycle.
- Output handshake: the lane contents transfer when `out_valid0 && out_ready`. Both lanes transfer together; no partial acceptance.
- While `out_valid0 && !out_ready`: the outputs, hold and state are stable, and `in_ready` = 0.
- `split_count` updates at the accept edge and is visible in N+1.

## Test plan
- Independent pair: `in_i0`=32'h00100093, `in_i1`=32'h00200113, RAW=0, `out_ready`=1 → next cycle both lanes valid with those words; `split_count`=0; `in_ready` stays 1.
- Dependent pair: `in_i0`=32'h00100093, `in_i1`=32'h00108113, RAW=1 →
  - N+1: lane 0 = 32'h00100093, lane 1 invalid, `in_ready`=0.
  - N+2: lane 0 = 32'h00108113.
  - N+2: `in_ready`=1; `split_count`=1.
- Single instruction with RAW=1 and `in_i1_valid`=0 → issues in one cycle with lane 1 invalid; no SPLIT; `split_count` unchanged.
- Back-pressure: dependent pair, `out_ready`=0 for 3 cycles after N+1 → lane 0 holds i0 for those 3 cycles with `in_ready`=0; held i1 appears the cycle after `out_ready` rises.
- Flush in SPLIT: dependent pair, then `flush`=1 in N+1 → N+2 both valids 0, state RUN, `in_ready`=1; i1 never issues; `split_count`=1.
- Reset mid-split: `rst`=1 in N+1 → N+2 all outputs 0, `split_count`=0; a fresh independent pair then issues normally.

Source files
------------

// File: rtl/dual_issue_sequencer.sv
// dual_issue_sequencer
// Issue-stage sequencer between fetch and the two execute lanes. Independent
// instruction pairs issue together; a pair whose i1 reads a register that i0
// writes is split and issued over two cycles, with i1 parked in a hold register.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid / in_ready        fetch handshake (in_ready is combinational)
//   in_i0, in_i1, in_i1_valid  instruction pair from fetch (i0 older)
//   has_RAW_dependence         i1 depends on i0, from the dependence detector
//   flush                      drop held and not-yet-accepted output instructions
//   out_ready                  execute lanes accept the current output
//   out_valid0/1, out_instr0/1 registered lane outputs
//   split_count                pairs split due to RAW, wraps at 2^CNT_W
module dual_issue_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_i0,
    input  logic [31:0]      in_i1,
    input  logic             in_i1_valid,
    input  logic             has_RAW_dependence,
    input  logic             flush,
    input  logic             out_ready,
    output logic             out_valid0,
    output logic [31:0]      out_instr0,
    output logic             out_valid1,
    output logic [31:0]      out_instr1,
    output logic [CNT_W-1:0] split_count
);

    localparam int unsigned INSTR_W = 32;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_SPLIT = 1'b1;

    logic [0:0]         state_q, state_d;
    logic               valid0_q, valid0_d;
    logic               valid1_q, valid1_d;
    logic [INSTR_W-1:0] instr0_q, instr0_d;
    logic [INSTR_W-1:0] instr1_q, instr1_d;
    logic [INSTR_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic adv;
    logic accept;
    logic split;

    // Output register may load when empty or being consumed this cycle.
    assign adv      = !valid0_q || out_ready;
    assign in_ready = (state_q == ST_RUN) && adv && !flush;
    assign accept   = in_valid && in_ready;
    // RAW is only meaningful when i1 is present.
    assign split    = accept && in_i1_valid && has_RAW_dependence;

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        valid0_d = valid0_q;
        valid1_d = valid1_q;
        instr0_d = instr0_q;
        instr1_d = instr1_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;

        if (flush) begin
            state_d  = ST_RUN;
            valid0_d = 1'b0;
            valid1_d = 1'b0;
            hold_d   = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (accept) begin
                        instr0_d = in_i0;
                        valid0_d = 1'b1;
                        if (split) begin
                            valid1_d = 1'b0;
                            hold_d   = in_i1;
                            state_d  = ST_SPLIT;
                            cnt_d    = cnt_q + CNT_W'(1);
                        end else begin
                            instr1_d = in_i1;
                            valid1_d = in_i1_valid;
                        end
                    end else if (adv) begin
                        valid0_d = 1'b0;
                        valid1_d = 1'b0;
                    end
                end
                ST_SPLIT: begin
                    // Issue the parked i1 alone on lane 0.
                    if (adv) begin
                        instr0_d = hold_q;
                        valid0_d = 1'b1;
                        valid1_d = 1'b0;
                        state_d  = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            instr0_q <= '0;
            instr1_q <= '0;
            hold_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            valid0_q <= valid0_d;
            valid1_q <= valid1_d;
            instr0_q <= instr0_d;
            instr1_q <= instr1_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid0  = valid0_q;
    assign out_valid1  = valid1_q;
    assign out_instr0  = instr0_q;
    assign out_instr1  = instr1_q;
    assign split_count = cnt_q;

endmodule

// File: tb/tb_dual_issue_sequencer.sv
// Testbench for dual_issue_sequencer: directed pairs, expected lane contents
// queued at issue and checked by a monitor on each output transfer.
module tb_dual_issue_sequencer;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_i0;
    logic [31:0]      in_i1;
    logic             in_i1_valid;
    logic             has_RAW_dependence;
    logic             flush;
    logic             out_ready;
    logic             out_valid0;
    logic [31:0]      out_instr0;
    logic             out_valid1;
    logic [31:0]      out_instr1;
    logic [CNT_W-1:0] split_count;

    typedef struct packed {
        logic [31:0] i0;
        logic        v1;
        logic [31:0] i1;
    } exp_t;

    exp_t exp_q[$];
    int   n_run  = 0;
    int   n_fail = 0;

    dual_issue_sequencer #(.CNT_W(CNT_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_i0              (in_i0),
        .in_i1              (in_i1),
        .in_i1_valid        (in_i1_valid),
        .has_RAW_dependence (has_RAW_dependence),
        .flush              (flush),
        .out_ready          (out_ready),
        .out_valid0         (out_valid0),
        .out_instr0         (out_instr0),
        .out_valid1         (out_valid1),
        .out_instr1         (out_instr1),
        .split_count        (split_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i0, input logic [31:0] i1,
                         input logic i1v, input logic raw);
        in_valid           = 1'b1;
        in_i0              = i0;
        in_i1              = i1;
        in_i1_valid        = i1v;
        has_RAW_dependence = raw;
        #1;
    endtask

    function automatic exp_t mk(input logic [31:0] i0, input logic v1, input logic [31:0] i1);
        exp_t e;
        e.i0 = i0;
        e.v1 = v1;
        e.i1 = i1;
        return e;
    endfunction

    // Monitor: every output transfer must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid1)
                chk("valid1_implies_valid0", 32'(out_valid0), 32'd1);
            if (out_valid0 && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_issue", out_instr0, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_instr0", out_instr0, e.i0);
                    chk("sb_valid1", 32'(out_valid1), 32'(e.v1));
                    if (e.v1)
                        chk("sb_instr1", out_instr1, e.i1);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_i0 = '0; in_i1 = '0; in_i1_valid = 1'b0;
        has_RAW_dependence = 1'b0; flush = 1'b0; out_ready = 1'b1;
        cyc(); cyc();
        chk("rst_valid0", 32'(out_valid0), 32'd0);
        chk("rst_valid1", 32'(out_valid1), 32'd0);
        chk("rst_instr0", out_instr0, 32'h0);
        chk("rst_instr1", out_instr1, 32'h0);
        chk("rst_count", 32'(split_count), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Independent pairs back to back.
        drive(32'h00100093, 32'h00200113, 1'b1, 1'b0);
        chk("ind_in_ready", 32'(in_ready), 32'd1);
        exp_q.push_back(mk(32'h00100093, 1'b1, 32'h00200113));
        cyc();
        drive(32'h00300193, 32'h00400213, 1'b1, 1'b0);
        chk("ind_valid1", 32'(out_valid1), 32'd1);
        chk("ind_in_ready2", 32'(in_ready), 32'd1);
        chk("ind_count", 32'(split_count), 32'd0);
        exp_q.push_back(mk(32'h00300193, 1'b1, 32'h00400213));
        cyc();
        in_valid = 1'b0;
        chk("ind2_instr0", out_instr0, 32'h00300193);
        cyc();
        chk("idle_valid0", 32'(out_valid0), 32'd0);

        // Dependent pair splits over two cycles.
        drive(32'h00100093, 32'h00108113, 1'b1, 1'b1);
        exp_q.push_back(mk(32'h00100093, 1'b0, 32'h0));
        exp_q.push_back(mk(32'h00108113, 1'b0, 32'h0));
        cyc();
        in_valid = 1'b0;
        #1;
        chk("dep_n1_instr0", out_instr0, 32'h00100093);
        chk("dep_n1_valid1", 32'(out_valid1), 32'd0);
        chk("dep_n1_in_ready", 32'(in_ready), 32'd0);
        cyc();
        chk("dep_n2_instr0", out_instr0, 32'h00108113);
        chk("dep_n2_valid0", 32'(out_valid0), 32'd1);
        chk("dep_n2_in_ready", 32'(in_ready), 32'd1);
        chk("dep_n2_count", 32'(split_count), 32'd1);
        cyc();
        chk("dep_n3_valid0", 32'(out_valid0), 32'd0);

        // Single instruction: RAW ignored without i1.
        drive(32'h00300193, 32'hDEADBEEF, 1'b0, 1'b1);
        exp_q.push_back(mk(32'h00300193, 1'b0, 32'h0));
        cyc();
        in_valid = 1'b0;
        #1;
        chk("single_valid1", 32'(out_valid1), 32'd0);
        chk("single_in_ready", 32'(in_ready), 32'd1);
        chk("single_count", 32'(split_count), 32'd1);
        cyc();

        // Back-pressure on a split pair.
        drive(32'h00500293, 32'h00528313, 1'b1, 1'b1);
        exp_q.push_back(mk(32'h00500293, 1'b0, 32'h0));
        exp_q.push_back(mk(32'h00528313, 1'b0, 32'h0));
        cyc();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_instr0", out_instr0, 32'h00500293);
            chk("bp_valid0", 32'(out_valid0), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_instr0", out_instr0, 32'h00500293);
        cyc();
        chk("bp_i1_instr0", out_instr0, 32'h00528313);
        chk("bp_count", 32'(split_count), 32'd2);
        cyc();

        // Flush while i1 is held: i1 never issues.
        drive(32'h00700393, 32'h00738413, 1'b1, 1'b1);
        exp_q.push_back(mk(32'h00700393, 1'b0, 32'h0));
        cyc();
        in_valid = 1'b0;
        flush    = 1'b1;
        #1;
        chk("fl_in_ready", 32'(in_ready), 32'd0);
        cyc();
        flush = 1'b0;
        #1;
        chk("fl_valid0", 32'(out_valid0), 32'd0);
        chk("fl_valid1", 32'(out_valid1), 32'd0);
        chk("fl_in_ready_after", 32'(in_ready), 32'd1);
        chk("fl_count", 32'(split_count), 32'd3);
        cyc(); cyc();

        // Flush in RUN blocks acceptance and leaves the counter alone.
        drive(32'h00900493, 32'h00948513, 1'b1, 1'b1);
        flush = 1'b1;
        #1;
        chk("flrun_in_ready", 32'(in_ready), 32'd0);
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flrun_valid0", 32'(out_valid0), 32'd0);
        chk("flrun_count", 32'(split_count), 32'd3);

        // Reset mid-split discards the held i1 and clears the counter.
        drive(32'h00900493, 32'h00948513, 1'b1, 1'b1);
        cyc();
        in_valid = 1'b0;
        rst      = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("rs_valid0", 32'(out_valid0), 32'd0);
        chk("rs_valid1", 32'(out_valid1), 32'd0);
        chk("rs_instr0", out_instr0, 32'h0);
        chk("rs_instr1", out_instr1, 32'h0);
        chk("rs_count", 32'(split_count), 32'd0);
        chk("rs_in_ready", 32'(in_ready), 32'd1);
        drive(32'h00a00593, 32'h00b00613, 1'b1, 1'b0);
        exp_q.push_back(mk(32'h00a00593, 1'b1, 32'h00b00613));
        cyc();
        in_valid = 1'b0;
        #1;
        chk("rs_fresh_valid1", 32'(out_valid1), 32'd1);
        chk("rs_fresh_count", 32'(split_count), 32'd0);
        cyc(); cyc(); cyc();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
